// File: rtl/switch_pkg.sv
// switch_in shared constants: read-bus address map and data width.
// Imported by switch_debounce and switch_in.
package switch_pkg;

  localparam int RDATA_W = 16;

  localparam logic [1:0] SW_ADDR_LO   = 2'b00;
  localparam logic [1:0] SW_ADDR_BTN  = 2'b01;
  localparam logic [1:0] SW_ADDR_HI   = 2'b10;
  localparam logic [1:0] SW_ADDR_FLAG = 2'b11;

endpackage

// File: rtl/switch_debounce.sv
// 2-FF synchroniser plus whole-vector debounce counter.
// A new value is accepted after DEBOUNCE_CYCLES stable cycles.
module switch_debounce
  import switch_pkg::*;
#(
  parameter int W               = 1,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] raw,
  output logic [W-1:0] stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]     meta;
  logic [W-1:0]     sync;
  logic [CNT_W-1:0] cnt;

  // meta != sync means sync takes a new value this edge: restart the count
  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= '0;
      sync   <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      if (sync == stable) begin
        cnt <= '0;
      end else if (meta != sync) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_in.sv
// Memory-mapped switch/button input port with sticky press flag.
// Define SWITCH_IRQ_EN to add the switch_irq output.
module switch_in
  import switch_pkg::*;
#(
  parameter int NUM_SW          = 16,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic               switch_clk,
  input  logic               switchrst,
  input  logic               switchcs,
  input  logic               switchread,
  input  logic [1:0]         switchaddr,
  input  logic [NUM_SW-1:0]  sw_in,
  input  logic               btn_in,
`ifdef SWITCH_IRQ_EN
  output logic               switch_irq,
`endif
  output logic [RDATA_W-1:0] switchrdata,
  output logic               switchrvalid
);

  logic [NUM_SW-1:0]  sw_stable;
  logic               btn_stable;
  logic               btn_d;
  logic               pressed;
  logic               rd_ok;
  logic               btn_rise;
  logic [RDATA_W-1:0] rsel;

  switch_debounce #(
    .W               (NUM_SW),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_db (
    .clk    (switch_clk),
    .rst    (switchrst),
    .raw    (sw_in),
    .stable (sw_stable)
  );

  switch_debounce #(
    .W               (1),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_db (
    .clk    (switch_clk),
    .rst    (switchrst),
    .raw    (btn_in),
    .stable (btn_stable)
  );

  assign rd_ok    = switchcs & switchread;
  assign btn_rise = btn_stable & ~btn_d;

  always_comb begin
    rsel = '0;
    case (switchaddr)
      SW_ADDR_LO:   rsel = {8'h00, sw_stable[7:0]};
      SW_ADDR_HI:   rsel = {8'h00, sw_stable[15:8]};
      SW_ADDR_BTN:  rsel = {15'b0, btn_stable};
      SW_ADDR_FLAG: rsel = {15'b0, pressed};
      default:      rsel = '0;
    endcase
  end

  // A rise beats a same-cycle read-clear so no press is lost
  always_ff @(posedge switch_clk) begin
    if (switchrst) begin
      btn_d        <= 1'b0;
      pressed      <= 1'b0;
      switchrvalid <= 1'b0;
      switchrdata  <= '0;
    end else begin
      btn_d        <= btn_stable;
      switchrvalid <= rd_ok;
      switchrdata  <= rd_ok ? rsel : '0;
      if (btn_rise)
        pressed <= 1'b1;
      else if (rd_ok && switchaddr == SW_ADDR_FLAG)
        pressed <= 1'b0;
    end
  end

`ifdef SWITCH_IRQ_EN
  always_ff @(posedge switch_clk) begin
    if (switchrst)
      switch_irq <= 1'b0;
    else
      switch_irq <= pressed;
  end
`endif

endmodule

// File: doc/switch_in.md
Name: switch_in

Overview:
- Memory-mapped input peripheral; the read-side counterpart of the LED output port.
- Samples 16 board switches and one confirm button, then synchronises and debounces them.
- Returns the stable values to the CPU when memorio asserts the switch chip-select with a read.
- Captures button presses in a sticky flag, so a program can poll for "user confirmed input".

Parameters:
- NUM_SW, 16, number of switch inputs; fixed at 16 for the 16-bit read bus.
- DEBOUNCE_CYCLES, 500000, consecutive switch_clk cycles an input must be stable before it is accepted (≥2).
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of each debounce counter.

Ports:
- switch_clk  in  1  clock (cpu_clk)
- switchrst  in  1  reset, synchronous, active-high
- switchcs  in  1  chip-select from memorio address decode
- switchread  in  1  read strobe, active-high
- switchaddr  in  2  00 = switch low byte, 10 = switch high byte, 01 = live button, 11 = pressed flag (read-clear)
- sw_in  in  16  raw asynchronous board switches
- btn_in  in  1  raw asynchronous confirm button
- switchrdata  out  16  registered read data
- switchrvalid  out  1  one-cycle pulse qualifying switchrdata

Behaviour:
- Clock and reset: single clock switch_clk; reset is synchronous and active-high on switchrst; all flops update only on posedge switch_clk.
- Reset values: all state clears to 0 on a switch_clk edge with switchrst=1. This covers synchroniser flops, stable vectors, counters, pressed flag, switchrdata=16'h0000 and switchrvalid=0. Reset mid-debounce discards the count.
- Synchroniser: 2-FF synchroniser on every sw_in bit and on btn_in. The synchronised value lags the pad by 2 cycles.
- Debounce: one counter for the whole 16-bit switch vector and a separate counter for the button.
  - sync == stable: counter held at 0.
  - sync != stable and sync unchanged from the previous cycle: counter increments.
  - sync changes while counting: counter restarts at 0.
  - Counter reaching DEBOUNCE_CYCLES-1: stable <= sync and counter <= 0 in the same edge.
  - Total pad-to-stable latency: 2 + DEBOUNCE_CYCLES cycles.
- Pressed flag: set on the cycle btn_stable goes 0->1. Cleared by an accepted read at addr 11.
  - Set and clear in the same cycle: the set wins and the flag stays 1, so no press is lost.
  - The read still returns the pre-edge value 0.
- Read handshake: a read is accepted when switchcs && switchread at a clock edge. At that edge:
  - switchrvalid <= 1.
  - switchrdata <= the value selected by switchaddr:
    - 00: {8'h00, sw_stable[7:0]}
    - 10: {8'h00, sw_stable[15:8]}
    - 01: {15'b0, btn_stable}
    - 11: {15'b0, pressed}
  - Latency is 1 cycle.
  - Back-to-back reads give one result per cycle.
- Idle cycles: on any cycle without an accepted read, switchrvalid <= 0 and switchrdata <= 0. This lets memorio OR-mux peripheral read buses.
- Writes: none. switchcs without switchread has no effect.

Optional Feature:
- SWITCH_IRQ_EN defined:
  - Adds output port switch_irq (1 bit) = registered copy of the pressed flag.
  - Asserts 1 cycle after the flag sets; deasserts 1 cycle after the read-clear.
  - Resets to 0.
- Not defined: port absent; all other behaviour identical.

Decomposition:
- Package switch_pkg:
  - Address localparams SW_ADDR_LO=2'b00, SW_ADDR_BTN=2'b01, SW_ADDR_HI=2'b10, SW_ADDR_FLAG=2'b11.
  - Read-data width constant 16.
- Sub-module switch_debounce #(W, DEBOUNCE_CYCLES): 2-FF synchroniser, counter, stable register.
  - Instantiated twice: W=16 for switches, W=1 for the button.
- Top level holds the edge detect, pressed flag and read mux.

Test Plan (all with DEBOUNCE_CYCLES=4):
- Reset: assert switchrst for 2 edges with sw_in=16'hFFFF. Required: switchrdata=0, switchrvalid=0, and a read at 00 returns 16'h0000 until 6 cycles after release.
- Clean switch change: sw_in=16'hA55A held. Required: read at 00 returns 16'h005A and read at 10 returns 16'h00A5, rvalid pulsing one cycle each, once 6 cycles have elapsed.
- Bounce: toggle sw_in[0] every 2 cycles for 20 cycles, then hold 1. Required: sw_stable[0] stays 0 throughout the bouncing and becomes 1 exactly 6 cycles after the final edge.
- Button press/read-clear: pulse btn_in high for 8 cycles. Required:
  - Read at 11 returns 16'h0001 and the next read at 11 returns 16'h0000.
  - Read at 01 during the press returns 16'h0001.
- Set/clear collision: issue a read at 11 on the exact cycle btn_stable rises. Required: that read returns 0, the flag remains 1, and the next read returns 1.
- Non-read cycles: switchcs=1 with switchread=0, and switchread=1 with switchcs=0. Required: switchrvalid=0, switchrdata=0, pressed flag unchanged. With SWITCH_IRQ_EN, switch_irq tracks the flag with 1-cycle lag.
